clk_lock_monitor: RTL and testbench



---
 rtl/clk_lock_monitor.sv | 174 +++++++++++++++++
 tb/tb_clk_lock_monitor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_lock_monitor.sv
// -----------------------------------------------------------------------------
// clk_lock_monitor
//
// Supervises a two-stage DCM clock generator from the free-running reference
// clock. It pulses the DCM user reset and waits for the DCM to lock. If lock
// does not arrive in time, it retries the reset. Once lock has been clean for a
// programmable number of cycles, it releases the system reset for the
// generated clock domains.
//
// Ports
//   CLK        in   1  free-running reference clock (never a DCM output)
//   RST_N      in   1  asynchronous, active-low reset
//   LOCKED     in   1  DCM lock flag, asynchronous to CLK
//   STATUS     in   8  DCM status; bit1 = CLKIN stopped, bit2 = CLKFX stopped
//   DCM_RST    out  1  DCM user reset, active high
//   SYS_RST    out  1  reset for generated-domain logic, active high
//   READY      out  1  clocks locked and stable
//   RETRY_CNT  out  8  saturating count of lock timeouts
//   LOSS_CNT   out 16  saturating count of RUN->DCM_RST transitions
//                      (present only with CLK_LOCK_MONITOR_LOSS_CNT_EN)
//   STATE      out  2  FSM state: 00 DCM_RST, 01 WAIT_LOCK, 10 STABLE, 11 RUN
//
// Optional feature macro: CLK_LOCK_MONITOR_LOSS_CNT_EN
//
// Handshake: none. All inputs are level signals sampled through synchronisers,
// and all outputs are registered levels.
// -----------------------------------------------------------------------------
module clk_lock_monitor #(
    parameter int DCM_RST_CYCLES = 4,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 256
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        LOCKED,
    input  logic [7:0]  STATUS,
    output logic        DCM_RST,
    output logic        SYS_RST,
    output logic        READY,
    output logic [7:0]  RETRY_CNT,
`ifdef CLK_LOCK_MONITOR_LOSS_CNT_EN
    output logic [15:0] LOSS_CNT,
`endif
    output logic [1:0]  STATE
);

    // One shared counter that is wide enough for the longest interval.
    localparam int MAX_AB = (DCM_RST_CYCLES > LOCK_TIMEOUT) ? DCM_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CNT_W  = (MAX_P > 2) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] DCM_LAST    = CNT_W'(DCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_DCM_RST   = 2'b00,
        S_WAIT_LOCK = 2'b01,
        S_STABLE    = 2'b10,
        S_RUN       = 2'b11
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             retry_inc;

    // Two-flop synchronisers for the asynchronous DCM flags.
    logic lock_m, lock_s;
    logic stop_in_m, stop_in_s;
    logic stop_fx_m, stop_fx_s;
    logic good;

    // Only STATUS[1] and STATUS[2] are meaningful here.
    logic status_unused;
    assign status_unused = ^{STATUS[7:3], STATUS[0]};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lock_m    <= 1'b0;
            lock_s    <= 1'b0;
            stop_in_m <= 1'b0;
            stop_in_s <= 1'b0;
            stop_fx_m <= 1'b0;
            stop_fx_s <= 1'b0;
        end else begin
            lock_m    <= LOCKED;
            lock_s    <= lock_m;
            stop_in_m <= STATUS[1];
            stop_in_s <= stop_in_m;
            stop_fx_m <= STATUS[2];
            stop_fx_s <= stop_fx_m;
        end
    end

    assign good = lock_s & ~stop_in_s & ~stop_fx_s;

    // Next-state decode. A good lock takes priority over the timeout.
    always_comb begin
        state_next = state;
        retry_inc  = 1'b0;
        case (state)
            S_DCM_RST: begin
                if (cnt == DCM_LAST) state_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (good) begin
                    state_next = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next = S_DCM_RST;
                    retry_inc  = 1'b1;
                end
            end
            S_STABLE: begin
                if (!good)                    state_next = S_WAIT_LOCK;
                else if (cnt == STABLE_LAST)  state_next = S_RUN;
            end
            S_RUN: begin
                if (!good) state_next = S_DCM_RST;
            end
            default: state_next = S_DCM_RST;
        endcase
    end

    // The state register and output flops load from the same decode, so the
    // resets and READY move on the same edge as STATE and never glitch.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_DCM_RST;
            DCM_RST <= 1'b1;
            SYS_RST <= 1'b1;
            READY   <= 1'b0;
        end else begin
            state   <= state_next;
            DCM_RST <= (state_next == S_DCM_RST);
            SYS_RST <= (state_next != S_RUN);
            READY   <= (state_next == S_RUN);
        end
    end

    // The counter restarts on every transition. It is not used in RUN, so it
    // is held there and never wraps.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else if (state != S_RUN) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RETRY_CNT <= 8'd0;
        end else if (retry_inc && (RETRY_CNT != 8'hFF)) begin
            RETRY_CNT <= RETRY_CNT + 8'd1;
        end
    end

`ifdef CLK_LOCK_MONITOR_LOSS_CNT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            LOSS_CNT <= 16'd0;
        end else if ((state == S_RUN) && (state_next == S_DCM_RST) &&
                     (LOSS_CNT != 16'hFFFF)) begin
            LOSS_CNT <= LOSS_CNT + 16'd1;
        end
    end
`endif

    assign STATE = state;

endmodule

// File: tb/tb_clk_lock_monitor.sv
module tb_clk_lock_monitor;

    localparam int DCM_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 100;
    localparam int STABLE_CYCLES  = 16;
    localparam int PERIOD         = DCM_RST_CYCLES + LOCK_TIMEOUT;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        LOCKED = 1'b0;
    logic [7:0]  STATUS = 8'h00;
    logic        DCM_RST;
    logic        SYS_RST;
    logic        READY;
    logic [7:0]  RETRY_CNT;
    logic [1:0]  STATE;
`ifdef CLK_LOCK_MONITOR_LOSS_CNT_EN
    logic [15:0] LOSS_CNT;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    // Clock / reset block
    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    clk_lock_monitor #(
        .DCM_RST_CYCLES(DCM_RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .LOCKED   (LOCKED),
        .STATUS   (STATUS),
        .DCM_RST  (DCM_RST),
        .SYS_RST  (SYS_RST),
        .READY    (READY),
        .RETRY_CNT(RETRY_CNT),
`ifdef CLK_LOCK_MONITOR_LOSS_CNT_EN
        .LOSS_CNT (LOSS_CNT),
`endif
        .STATE    (STATE)
    );

    // Driver tasks: inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (STATE === s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; LOCKED = 1'b1; STATUS = 8'h00;
        tick(3);
        checks++; if (STATE !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", STATE); end
        checks++; if (DCM_RST !== 1'b1) begin errors++; $display("FAIL reset_dcm_rst: got %b expected 1", DCM_RST); end
        checks++; if (SYS_RST !== 1'b1) begin errors++; $display("FAIL reset_sys_rst: got %b expected 1", SYS_RST); end
        checks++; if (READY !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", READY); end
        checks++; if (RETRY_CNT !== 8'd0) begin errors++; $display("FAIL reset_retry: got %0d expected 0", RETRY_CNT); end
`ifdef CLK_LOCK_MONITOR_LOSS_CNT_EN
        checks++; if (LOSS_CNT !== 16'd0) begin errors++; $display("FAIL reset_loss: got %0d expected 0", LOSS_CNT); end
`endif
    endtask

    task automatic test_power_up();
        RST_N = 1'b1;
        for (int i = 1; i < DCM_RST_CYCLES; i++) begin
            tick(1);
            checks++; if (DCM_RST !== 1'b1 || STATE !== 2'b00) begin errors++; $display("FAIL pwr_dcm_hold[%0d]: got dcm=%b state=%b expected 1/00", i, DCM_RST, STATE); end
        end
        tick(1);
        checks++; if (DCM_RST !== 1'b0 || STATE !== 2'b01) begin errors++; $display("FAIL pwr_wait_lock: got dcm=%b state=%b expected 0/01", DCM_RST, STATE); end
        checks++; if (SYS_RST !== 1'b1) begin errors++; $display("FAIL pwr_sys_rst_wait: got %b expected 1", SYS_RST); end
        tick(1);
        checks++; if (STATE !== 2'b10) begin errors++; $display("FAIL pwr_stable: got %b expected 10", STATE); end
        tick(STABLE_CYCLES - 1);
        checks++; if (READY !== 1'b0 || SYS_RST !== 1'b1 || STATE !== 2'b10) begin errors++; $display("FAIL pwr_early_ready: got rdy=%b sys=%b state=%b expected 0/1/10", READY, SYS_RST, STATE); end
        tick(1);
        checks++; if (READY !== 1'b1 || SYS_RST !== 1'b0 || STATE !== 2'b11) begin errors++; $display("FAIL pwr_ready: got rdy=%b sys=%b state=%b expected 1/0/11", READY, SYS_RST, STATE); end
    endtask

    task automatic test_lock_loss();
        bit ok;
        LOCKED = 1'b0;
        tick(2);
        checks++; if (STATE !== 2'b11 || READY !== 1'b1) begin errors++; $display("FAIL loss_sync_delay: got state=%b rdy=%b expected 11/1", STATE, READY); end
        tick(1);
        checks++; if (STATE !== 2'b00 || DCM_RST !== 1'b1 || SYS_RST !== 1'b1 || READY !== 1'b0) begin errors++; $display("FAIL loss_response: got state=%b dcm=%b sys=%b rdy=%b expected 00/1/1/0", STATE, DCM_RST, SYS_RST, READY); end
`ifdef CLK_LOCK_MONITOR_LOSS_CNT_EN
        checks++; if (LOSS_CNT !== 16'd1) begin errors++; $display("FAIL loss_cnt_1: got %0d expected 1", LOSS_CNT); end
`endif
        LOCKED = 1'b1;
        wait_state(2'b11, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL loss_relock: timed out, state=%b expected 11", STATE); end
    endtask

    task automatic test_clock_stopped();
        bit ok;
        STATUS = 8'h04;
        tick(2);
        checks++; if (STATE !== 2'b11) begin errors++; $display("FAIL stop_sync_delay: got %b expected 11", STATE); end
        tick(1);
        checks++; if (STATE !== 2'b00 || DCM_RST !== 1'b1 || SYS_RST !== 1'b1 || READY !== 1'b0) begin errors++; $display("FAIL stop_response: got state=%b dcm=%b sys=%b rdy=%b expected 00/1/1/0", STATE, DCM_RST, SYS_RST, READY); end
`ifdef CLK_LOCK_MONITOR_LOSS_CNT_EN
        checks++; if (LOSS_CNT !== 16'd2) begin errors++; $display("FAIL loss_cnt_2: got %0d expected 2", LOSS_CNT); end
`endif
        STATUS = 8'h00;
        wait_state(2'b11, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stop_relock: timed out, state=%b expected 11", STATE); end
    endtask

    task automatic test_unstable_lock();
        bit ok;
        LOCKED = 1'b0;
        wait_state(2'b01, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL unst_enter_wait: timed out, state=%b expected 01", STATE); end
        LOCKED = 1'b1;
        tick(3);
        checks++; if (STATE !== 2'b10) begin errors++; $display("FAIL unst_stable: got %b expected 10", STATE); end
        tick(7);
        LOCKED = 1'b0;
        tick(1);
        LOCKED = 1'b1;
        tick(1);
        checks++; if (STATE !== 2'b10) begin errors++; $display("FAIL unst_pre_drop: got %b expected 10", STATE); end
        tick(1);
        checks++; if (STATE !== 2'b01) begin errors++; $display("FAIL unst_drop: got %b expected 01", STATE); end
        tick(1);
        checks++; if (STATE !== 2'b10) begin errors++; $display("FAIL unst_restable: got %b expected 10", STATE); end
        tick(STABLE_CYCLES - 1);
        checks++; if (READY !== 1'b0 || STATE !== 2'b10) begin errors++; $display("FAIL unst_early_ready: got rdy=%b state=%b expected 0/10", READY, STATE); end
        tick(1);
        checks++; if (READY !== 1'b1 || STATE !== 2'b11) begin errors++; $display("FAIL unst_ready: got rdy=%b state=%b expected 1/11", READY, STATE); end
        checks++; if (RETRY_CNT !== 8'd0) begin errors++; $display("FAIL unst_retry: got %0d expected 0", RETRY_CNT); end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [7:0] exp;
        exp_q.push_back(8'd1); exp_q.push_back(8'd2); exp_q.push_back(8'd3);
        LOCKED = 1'b0;
        wait_state(2'b01, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_enter_wait: timed out, state=%b expected 01", STATE); end
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            tick(LOCK_TIMEOUT - 1);
            checks++; if (STATE !== 2'b01) begin errors++; $display("FAIL to_still_wait[%0d]: got %b expected 01", exp, STATE); end
            tick(1);
            checks++; if (STATE !== 2'b00 || DCM_RST !== 1'b1 || RETRY_CNT !== exp) begin errors++; $display("FAIL to_retry[%0d]: got state=%b dcm=%b cnt=%0d expected 00/1/%0d", exp, STATE, DCM_RST, RETRY_CNT, exp); end
            tick(DCM_RST_CYCLES - 1);
            checks++; if (DCM_RST !== 1'b1) begin errors++; $display("FAIL to_dcm_width[%0d]: got %b expected 1", exp, DCM_RST); end
            tick(1);
            checks++; if (DCM_RST !== 1'b0 || STATE !== 2'b01) begin errors++; $display("FAIL to_dcm_end[%0d]: got dcm=%b state=%b expected 0/01", exp, DCM_RST, STATE); end
        end
    endtask

    // Entered just after WAIT_LOCK began; LOCKED is raised so the synchronised
    // flag reaches the FSM on the same cycle as the final timeout count.
    task automatic test_simultaneous();
        tick(LOCK_TIMEOUT - 3);
        LOCKED = 1'b1;
        tick(2);
        checks++; if (STATE !== 2'b01) begin errors++; $display("FAIL sim_pre: got %b expected 01", STATE); end
        tick(1);
        checks++; if (STATE !== 2'b10 || DCM_RST !== 1'b0) begin errors++; $display("FAIL sim_good_wins: got state=%b dcm=%b expected 10/0", STATE, DCM_RST); end
        checks++; if (RETRY_CNT !== 8'd3) begin errors++; $display("FAIL sim_retry_same: got %0d expected 3", RETRY_CNT); end
    endtask

    task automatic test_reset_mid_stable();
        tick(2);
        checks++; if (STATE !== 2'b10) begin errors++; $display("FAIL rst_pre: got %b expected 10", STATE); end
        #2 RST_N = 1'b0;
        #1;
        checks++; if (STATE !== 2'b00 || DCM_RST !== 1'b1 || SYS_RST !== 1'b1 || READY !== 1'b0) begin errors++; $display("FAIL rst_async: got state=%b dcm=%b sys=%b rdy=%b expected 00/1/1/0", STATE, DCM_RST, SYS_RST, READY); end
        checks++; if (RETRY_CNT !== 8'd0) begin errors++; $display("FAIL rst_retry_clear: got %0d expected 0", RETRY_CNT); end
        @(negedge CLK);
    endtask

    task automatic test_retry_saturation();
        LOCKED = 1'b0;
        RST_N = 1'b1;
        tick(DCM_RST_CYCLES);
        checks++; if (STATE !== 2'b01) begin errors++; $display("FAIL sat_start: got %b expected 01", STATE); end
        tick(254 * PERIOD);
        checks++; if (RETRY_CNT !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", RETRY_CNT); end
        tick(PERIOD);
        checks++; if (RETRY_CNT !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", RETRY_CNT); end
        tick(45 * PERIOD);
        checks++; if (RETRY_CNT !== 8'd255 || STATE !== 2'b01) begin errors++; $display("FAIL sat_300: got cnt=%0d state=%b expected 255/01", RETRY_CNT, STATE); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_loss();
        test_clock_stopped();
        test_unstable_lock();
        test_timeout();
        test_simultaneous();
        test_reset_mid_stable();
        test_retry_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
